// File: rtl/mux_pkg.sv
// Shared constants, types and sizing helper for the N-way registered stream mux.
package mux_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Width of a channel index; never below 1 so a degenerate N still yields a legal vector.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: first valid channel searching upward from ptr+1 with wrap.
// Purely combinational; gnt_vld_o is low when no channel is valid.
module rr_grant #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    vld_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            gnt_vld_o
);

  int         idx;
  logic [N-1:0] vld_sh;

  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    vld_sh    = '0;
    for (int k = 1; k <= N; k++) begin
      idx    = (int'(ptr_i) + k) % N;
      vld_sh = vld_i >> idx;
      if (!gnt_vld_o && vld_sh[0]) begin
        gnt_o     = SELW'(idx);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-way, WIDTH-bit registered stream mux with a one-entry output register; 1-cycle latency.
// Optional round-robin arbitration and the Rr_mode port exist only when ROUND_ROBIN_EN is defined.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  parameter int SELW  = chan_w(N)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N*WIDTH-1:0] In_data,
  input  logic [N-1:0]       In_valid,
  output logic [N-1:0]       In_ready,
  input  logic [SELW-1:0]    Sel,
`ifdef ROUND_ROBIN_EN
  input  logic               Rr_mode,
`endif
  output logic [WIDTH-1:0]   Out_data,
  output logic [SELW-1:0]    Out_chan,
  output logic               Out_valid,
  input  logic               Out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [SELW-1:0]  chan_q, chan_d;

  logic             load;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             xfer;
  logic [WIDTH-1:0] sel_dat;

  assign load = (state_q == EMPTY) | Out_ready;

`ifdef ROUND_ROBIN_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] rr_gnt;
  logic            rr_gnt_vld;

  rr_grant #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_grant (
    .vld_i     (In_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (rr_gnt),
    .gnt_vld_o (rr_gnt_vld)
  );

  assign grant     = Rr_mode ? rr_gnt : Sel;
  assign grant_vld = Rr_mode ? rr_gnt_vld : (int'(Sel) < N);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && Rr_mode) ptr_d = grant;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) ptr_q <= SELW'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  assign grant     = Sel;
  assign grant_vld = (int'(Sel) < N);
`endif

  // Ready is offered to the granted channel regardless of its valid, so Sel mode never loops valid->ready.
  always_comb begin
    In_ready = '0;
    sel_dat  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vld && (grant == SELW'(i))) begin
        In_ready[i] = load;
        sel_dat     = In_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(In_ready & In_valid);

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    chan_d  = chan_q;
    if (xfer) begin
      state_d = FULL;
      dat_d   = sel_dat;
      chan_d  = grant;
    end else if (Out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      dat_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      chan_q  <= chan_d;
    end
  end

  assign Out_valid = (state_q == FULL);
  assign Out_data  = dat_q;
  assign Out_chan  = chan_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench: a 4-channel instance for the main behaviour, a 5-channel one for out-of-range Sel.
module tb_mux_nx1_stream;

  logic        clk;
  logic        rst_n;

  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [79:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [2:0]  sel5;
  logic [15:0] out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;
  logic        out_ready5;

`ifdef ROUND_ROBIN_EN
  logic        rr_mode;
`endif

  int errs;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_stream #(.WIDTH(16), .N(4)) u_dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .In_data   (in_data),
    .In_valid  (in_valid),
    .In_ready  (in_ready),
    .Sel       (sel),
`ifdef ROUND_ROBIN_EN
    .Rr_mode   (rr_mode),
`endif
    .Out_data  (out_data),
    .Out_chan  (out_chan),
    .Out_valid (out_valid),
    .Out_ready (out_ready)
  );

  mux_nx1_stream #(.WIDTH(16), .N(5)) u_dut5 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .In_data   (in_data5),
    .In_valid  (in_valid5),
    .In_ready  (in_ready5),
    .Sel       (sel5),
`ifdef ROUND_ROBIN_EN
    .Rr_mode   (1'b0),
`endif
    .Out_data  (out_data5),
    .Out_chan  (out_chan5),
    .Out_valid (out_valid5),
    .Out_ready (out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [15:0] v);
    in_data[i*16 +: 16] = v;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    out_ready  = 1'b0;
    in_data5   = '0;
    in_valid5  = '0;
    sel5       = '0;
    out_ready5 = 1'b0;
`ifdef ROUND_ROBIN_EN
    rr_mode    = 1'b0;
`endif

    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_chan",  32'(out_chan),  32'h0);
    chk("rst_valid5", 32'(out_valid5), 32'h0);

    // First transfer in the first cycle after reset release
    rst_n     = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    set_ch(2, 16'h0003);
    out_ready = 1'b1;
    #1;
    chk("sel2_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("sel2_valid", 32'(out_valid), 32'h1);
    chk("sel2_data",  32'(out_data),  32'h0003);
    chk("sel2_chan",  32'(out_chan),  32'h2);

    // Stall: hold 0002 while ch1 waits with 0009
    sel      = 2'd0;
    in_valid = 4'b0001;
    set_ch(0, 16'h0002);
    tick();
    chk("fill_data", 32'(out_data), 32'h0002);
    out_ready = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    set_ch(1, 16'h0009);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_ready", 32'(in_ready), 32'h0);
      tick();
      chk("stall_data",  32'(out_data),  32'h0002);
      chk("stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("unstall_data", 32'(out_data), 32'h0009);
    chk("unstall_chan", 32'(out_chan), 32'h1);
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Back-to-back stream on ch0
    sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 4'b0001;
      set_ch(0, 16'(k));
      tick();
      chk("b2b_valid", 32'(out_valid), 32'h1);
      chk("b2b_data",  32'(out_data),  32'(k));
    end
    in_valid = 4'b0000;
    tick();
    chk("b2b_end_valid", 32'(out_valid), 32'h0);

    // Ready in Sel mode is offered even without valid
    sel = 2'd3;
    #1;
    chk("novld_ready", 32'(in_ready), 32'b1000);

    // Out-of-range Sel on the 5-channel instance
    in_data5   = {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01, 16'h0E00};
    in_valid5  = 5'b11111;
    out_ready5 = 1'b1;
    sel5       = 3'd5;
    #1;
    chk("sel5_ready", 32'(in_ready5), 32'h0);
    tick();
    tick();
    chk("sel5_valid", 32'(out_valid5), 32'h0);
    sel5 = 3'd7;
    #1;
    chk("sel7_ready", 32'(in_ready5), 32'h0);
    sel5 = 3'd4;
    #1;
    chk("sel4_ready", 32'(in_ready5), 32'b10000);
    tick();
    chk("sel4_valid", 32'(out_valid5), 32'h1);
    chk("sel4_data",  32'(out_data5),  32'h0E04);
    chk("sel4_chan",  32'(out_chan5),  32'h4);

`ifdef ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) set_ch(i, 16'(16'h0100 + i));
    rr_mode   = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("rr_none_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b1111;
    begin
      logic [1:0] exp_all [5];
      exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("rr_all_chan", 32'(out_chan), 32'(exp_all[k]));
        chk("rr_all_data", 32'(out_data), 32'(16'h0100 + exp_all[k]));
      end
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_odd_chan", 32'(out_chan), (k % 2 == 0) ? 32'h1 : 32'h3);
    end
    // Park the pointer on ch1 so a restart at ch0 proves the reset
    in_valid = 4'b1111;
    tick();
    chk("rr_park0", 32'(out_chan), 32'h0);
    tick();
    chk("rr_park1", 32'(out_chan), 32'h1);
    rr_mode  = 1'b0;
    in_valid = 4'b0000;
    tick();
`endif

    // Reset while full and stalled
    sel       = 2'd1;
    in_valid  = 4'b0010;
    set_ch(1, 16'h00AA);
    out_ready = 1'b1;
    tick();
    chk("pre_rst_data", 32'(out_data), 32'h00AA);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    tick();
    chk("pre_rst_hold", 32'(out_data), 32'h00AA);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data",  32'(out_data),  32'h0);
    rst_n = 1'b1;

`ifdef ROUND_ROBIN_EN
    rr_mode   = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    chk("rr_restart_chan", 32'(out_chan), 32'h0);
    rr_mode  = 1'b0;
    in_valid = 4'b0000;
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
